// File: rtl/vga_coord_fetch.sv
// Fetches NUM_WORDS sprite coordinate words from memory on each frame start and
// presents each one for a single cycle, tagged with its slot index, to the VGA bit generator.
module vga_coord_fetch #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          NUM_WORDS = 6,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk_50m,
  input  logic        btn_rst_n,
  input  logic        frame_start,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  vga_counter,
  output logic [15:0] data_from_mem_vga,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  lat_q, lat_d;
  logic        pending_q, pending_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, frame_done_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    pending_d = pending_q;
    data_d    = data_q;

    // Only one frame can be queued behind the active fetch; extra pulses are lost.
    if (state_q != S_IDLE && frame_start) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start || pending_q) begin
          state_d   = S_REQ;
          idx_d     = 3'd0;
          pending_d = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = S_WAIT;
          lat_d   = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 3'd0) begin
          data_d  = mem_rdata;
          state_d = S_PRESENT;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_PRESENT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        // A start arriving in this very cycle chains straight into the next fetch.
        if (pending_q || frame_start) begin
          state_d   = S_REQ;
          idx_d     = 3'd0;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!btn_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      lat_q        <= 3'd0;
      pending_q    <= 1'b0;
      data_q       <= 16'h0000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      pending_q    <= pending_d;
      data_q       <= data_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_DONE);
    end
  end

  assign mem_req           = (state_q == S_REQ);
  assign mem_addr          = mem_req ? (BASE_ADDR + {13'd0, idx_q}) : 16'h0000;
  assign vga_counter       = (state_q == S_PRESENT) ? idx_q : 3'b111;
  assign data_from_mem_vga = data_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_vga_coord_fetch.sv
// Directed bench: default instance (RD_LAT=1, base 0) and a second instance with RD_LAT=3, base 16'hFFFE.
module tb_vga_coord_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, fs_a, gnt_a, req_a, busy_a, fd_a;
  logic [15:0] addr_a, rdata_a, dat_a;
  logic [2:0]  vc_a;
  logic        rst_b_n, fs_b, gnt_b, req_b, busy_b, fd_b;
  logic [15:0] addr_b, rdata_b, dat_b;
  logic [2:0]  vc_b;

  vga_coord_fetch dut_a (
    .clk_50m(clk), .btn_rst_n(rst_a_n), .frame_start(fs_a),
    .mem_req(req_a), .mem_addr(addr_a), .mem_gnt(gnt_a), .mem_rdata(rdata_a),
    .vga_counter(vc_a), .data_from_mem_vga(dat_a), .busy(busy_a), .frame_done(fd_a)
  );

  vga_coord_fetch #(.BASE_ADDR(16'hFFFE), .NUM_WORDS(6), .RD_LAT(3)) dut_b (
    .clk_50m(clk), .btn_rst_n(rst_b_n), .frame_start(fs_b),
    .mem_req(req_b), .mem_addr(addr_b), .mem_gnt(gnt_b), .mem_rdata(rdata_b),
    .vga_counter(vc_b), .data_from_mem_vga(dat_b), .busy(busy_b), .frame_done(fd_b)
  );

  // Memory A: one-cycle registered read, junk whenever no transfer happened.
  logic [15:0] mem_a [0:7];
  always @(posedge clk) rdata_a <= (req_a && gnt_a) ? mem_a[addr_a[2:0]] : 16'hEEEE;

  // Memory B: three-stage read pipeline; data is only valid in the single return cycle.
  function automatic logic [15:0] mem_b(input logic [15:0] a);
    return (a == 16'hFFFE) ? 16'hDEAD : (a ^ 16'h1234);
  endfunction
  logic [16:0] pb1 = '0, pb2 = '0, pb3 = '0;
  logic [7:0]  gcnt = '0;
  logic [15:0] gaddr[$];
  always @(posedge clk) begin
    gcnt <= gcnt + 8'd1;
    pb1  <= {req_b && gnt_b, mem_b(addr_b)};
    pb2  <= pb1;
    pb3  <= pb2;
    if (req_b && gnt_b) gaddr.push_back(addr_b);
  end
  assign rdata_b = pb3[16] ? pb3[15:0] : {8'hBA, gcnt};

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, exp);
    end
  endtask

  logic [2:0]  t_vc   [0:79];
  logic [15:0] t_dat  [0:79];
  logic [15:0] t_addr [0:79];
  logic        t_fd   [0:79];
  logic        t_busy [0:79];
  logic        t_req  [0:79];

  // Cycle c: inputs driven just after its rising edge, outputs sampled on its falling edge.
  task automatic run(input bit use_b, input logic [63:0] fs_mask, input int st_lo,
                     input int st_hi, input int rst_cyc, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (use_b) fs_b = fs_mask[c]; else fs_a = fs_mask[c];
      gnt_a   = !(c >= st_lo && c <= st_hi);
      rst_a_n = (c != rst_cyc);
      @(negedge clk);
      t_vc[c]   = use_b ? vc_b   : vc_a;
      t_dat[c]  = use_b ? dat_b  : dat_a;
      t_addr[c] = use_b ? addr_b : addr_a;
      t_fd[c]   = use_b ? fd_b   : fd_a;
      t_busy[c] = use_b ? busy_b : busy_a;
      t_req[c]  = use_b ? req_b  : req_a;
    end
    @(posedge clk); #1;
    fs_a = 1'b0; fs_b = 1'b0; gnt_a = 1'b1; rst_a_n = 1'b1;
  endtask

  typedef struct {
    int          cyc;
    logic [2:0]  vc;
    logic [15:0] dat;
    logic        fd;
    logic        busy;
    logic        req;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl [14];
  logic [15:0] exp_words [0:5];
  logic [15:0] wrap_addr [0:5];

  initial begin
    int n;
    logic [2:0] evc;

    tbl[0]  = '{0,  3'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1,  3'd7, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};
    tbl[2]  = '{2,  3'd7, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{3,  3'd0, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[4]  = '{4,  3'd7, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0001};
    tbl[5]  = '{6,  3'd1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[6]  = '{7,  3'd7, 16'h0020, 1'b0, 1'b1, 1'b1, 16'h0002};
    tbl[7]  = '{9,  3'd2, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[8]  = '{12, 3'd3, 16'h0120, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[9]  = '{15, 3'd4, 16'h0200, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[10] = '{16, 3'd7, 16'h0200, 1'b0, 1'b1, 1'b1, 16'h0005};
    tbl[11] = '{18, 3'd5, 16'h0130, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[12] = '{19, 3'd7, 16'h0130, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[13] = '{20, 3'd7, 16'h0130, 1'b0, 1'b0, 1'b0, 16'h0000};

    exp_words[0] = 16'h0010; exp_words[1] = 16'h0020; exp_words[2] = 16'h0100;
    exp_words[3] = 16'h0120; exp_words[4] = 16'h0200; exp_words[5] = 16'h0130;
    for (int i = 0; i < 6; i++) mem_a[i] = exp_words[i];
    mem_a[6] = 16'hE006; mem_a[7] = 16'hE007;
    wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF; wrap_addr[2] = 16'h0000;
    wrap_addr[3] = 16'h0001; wrap_addr[4] = 16'h0002; wrap_addr[5] = 16'h0003;

    rst_a_n = 1'b0; rst_b_n = 1'b0; fs_a = 1'b0; fs_b = 1'b0; gnt_a = 1'b1; gnt_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vc",   0, 32'(vc_a),   32'h7);
    check("rst_dat",  0, 32'(dat_a),  32'h0);
    check("rst_req",  0, 32'(req_a),  32'h0);
    check("rst_addr", 0, 32'(addr_a), 32'h0);
    check("rst_busy", 0, 32'(busy_a), 32'h0);
    check("rst_fd",   0, 32'(fd_a),   32'h0);
    @(posedge clk); #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Basic fetch
    run(1'b0, 64'h1, -1, -1, -1, 22);
    for (int i = 0; i < 14; i++) begin
      check("basic_vc",   tbl[i].cyc, 32'(t_vc[tbl[i].cyc]),   32'(tbl[i].vc));
      check("basic_dat",  tbl[i].cyc, 32'(t_dat[tbl[i].cyc]),  32'(tbl[i].dat));
      check("basic_fd",   tbl[i].cyc, 32'(t_fd[tbl[i].cyc]),   32'(tbl[i].fd));
      check("basic_busy", tbl[i].cyc, 32'(t_busy[tbl[i].cyc]), 32'(tbl[i].busy));
      check("basic_req",  tbl[i].cyc, 32'(t_req[tbl[i].cyc]),  32'(tbl[i].req));
      check("basic_addr", tbl[i].cyc, 32'(t_addr[tbl[i].cyc]), 32'(tbl[i].addr));
    end
    for (int c = 0; c < 22; c++) begin
      evc = (c >= 3 && c <= 18 && (c % 3) == 0) ? 3'((c - 3) / 3) : 3'd7;
      check("basic_vc_all", c, 32'(t_vc[c]), 32'(evc));
      if (evc != 3'd7) check("basic_word", c, 32'(t_dat[c]), 32'(exp_words[evc]));
    end

    // Grant stall on word 2
    run(1'b0, 64'h1, 7, 10, -1, 26);
    for (int c = 7; c <= 11; c++) begin
      check("stall_req",  c, 32'(t_req[c]),  32'h1);
      check("stall_addr", c, 32'(t_addr[c]), 32'h2);
    end
    check("stall_req_end", 12, 32'(t_req[12]), 32'h0);
    check("stall_vc2",     13, 32'(t_vc[13]),  32'h2);
    check("stall_dat2",    13, 32'(t_dat[13]), 32'h0100);
    check("stall_vc5",     22, 32'(t_vc[22]),  32'h5);
    check("stall_fd_early",19, 32'(t_fd[19]),  32'h0);
    check("stall_fd",      23, 32'(t_fd[23]),  32'h1);
    check("stall_busy",    23, 32'(t_busy[23]),32'h1);
    check("stall_busy_off",24, 32'(t_busy[24]),32'h0);

    // Overlapping frame starts in cycles 0, 5, 9
    run(1'b0, 64'h221, -1, -1, -1, 60);
    n = 0;
    for (int c = 0; c < 60; c++) if (t_fd[c]) n++;
    check("ovl_fd_count", 0, 32'(n), 32'd2);
    n = 0;
    for (int c = 0; c < 60; c++) if (t_vc[c] != 3'd7) n++;
    check("ovl_present_count", 0, 32'(n), 32'd12);
    check("ovl_fd1",   19, 32'(t_fd[19]),   32'h1);
    check("ovl_req2",  20, 32'(t_req[20]),  32'h1);
    check("ovl_addr2", 20, 32'(t_addr[20]), 32'h0);
    check("ovl_busy2", 20, 32'(t_busy[20]), 32'h1);
    check("ovl_vc0",   22, 32'(t_vc[22]),   32'h0);
    check("ovl_dat0",  22, 32'(t_dat[22]),  32'h0010);
    check("ovl_vc5",   37, 32'(t_vc[37]),   32'h5);
    check("ovl_fd2",   38, 32'(t_fd[38]),   32'h1);
    check("ovl_busy_off", 39, 32'(t_busy[39]), 32'h0);
    n = 0;
    for (int c = 39; c < 60; c++) if (t_req[c]) n++;
    check("ovl_no_third", 39, 32'(n), 32'd0);

    // Reset in cycle 7 of a fetch, then a clean fetch
    run(1'b0, 64'h1, -1, -1, 7, 24);
    check("rstm_req",  8, 32'(t_req[8]),  32'h0);
    check("rstm_vc",   8, 32'(t_vc[8]),   32'h7);
    check("rstm_dat",  8, 32'(t_dat[8]),  32'h0);
    check("rstm_busy", 8, 32'(t_busy[8]), 32'h0);
    n = 0;
    for (int c = 0; c < 24; c++) if (t_fd[c]) n++;
    check("rstm_no_fd", 0, 32'(n), 32'd0);
    n = 0;
    for (int c = 8; c < 24; c++) if (t_req[c] || t_vc[c] != 3'd7) n++;
    check("rstm_quiet", 8, 32'(n), 32'd0);
    run(1'b0, 64'h1, -1, -1, -1, 22);
    check("rstm_re_req",  1,  32'(t_req[1]),  32'h1);
    check("rstm_re_addr", 1,  32'(t_addr[1]), 32'h0);
    check("rstm_re_vc",   3,  32'(t_vc[3]),   32'h0);
    check("rstm_re_dat",  3,  32'(t_dat[3]),  32'h0010);
    check("rstm_re_fd",   19, 32'(t_fd[19]),  32'h1);

    // RD_LAT=3 and address wrap on the second instance
    gaddr.delete();
    run(1'b1, 64'h1, -1, -1, -1, 36);
    check("lat_addr0", 1,  32'(t_addr[1]), 32'hFFFE);
    check("lat_vc_wait", 4, 32'(t_vc[4]), 32'h7);
    check("lat_vc0",   5,  32'(t_vc[5]),   32'h0);
    check("lat_dat0",  5,  32'(t_dat[5]),  32'hDEAD);
    check("lat_vc1",   10, 32'(t_vc[10]),  32'h1);
    check("lat_dat1",  10, 32'(t_dat[10]), 32'hEDCB);
    check("lat_vc5",   30, 32'(t_vc[30]),  32'h5);
    check("lat_dat5",  30, 32'(t_dat[30]), 32'h1237);
    check("lat_fd_early", 30, 32'(t_fd[30]), 32'h0);
    check("lat_fd",    31, 32'(t_fd[31]),  32'h1);
    check("wrap_count", 0, 32'(gaddr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < gaddr.size()) check("wrap_addr", i, 32'(gaddr[i]), 32'(wrap_addr[i]));
      else check("wrap_addr_missing", i, 32'h0, 32'(wrap_addr[i]) | 32'h10000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_coord_fetch.md
# vga_coord_fetch

Memory-side reader that feeds the VGA sprite bit generator with per-frame sprite coordinates. On each frame-start pulse it reads six consecutive 16-bit words from data memory: monkey x/y, platform-1 x/y and platform-2 x/y. It presents each word on `data_from_mem_vga` with its slot index on `vga_counter`, so the bit generator latches every coordinate into the matching register. It sits between the memory read arbiter and the bit generator, in the `clk_50m` domain.

## Interface
- `BASE_ADDR`, 16'h0000: address of word 0 (monkey x); word *i* is at `BASE_ADDR + i`.
- `NUM_WORDS`, 6: words fetched per frame; legal range 1–7.
- `RD_LAT`, 1: cycles from the grant edge to valid `mem_rdata`; legal range 1–7.

- `clk_50m`  in  1  system clock; all logic on rising edge.
- `btn_rst_n`  in  1  reset; synchronous, active-low.
- `frame_start`  in  1  single-cycle pulse, synchronous to `clk_50m`, at start of each frame.
- `mem_req`  out  1  read request; held until granted.
- `mem_addr`  out  16  read address; stable while `mem_req` is high.
- `mem_gnt`  in  1  arbiter accept; a transfer occurs on an edge where `mem_req && mem_gnt`.
- `mem_rdata`  in  16  read data; valid `RD_LAT` cycles after the grant edge.
- `vga_counter`  out  3  slot index 0..NUM_WORDS-1 while presenting; 3'b111 otherwise.
- `data_from_mem_vga`  out  16  coordinate word; holds the last value between presentations.
- `busy`  out  1  high from the first REQ cycle until the DONE state is left.
- `frame_done`  out  1  one-cycle pulse after the last word is presented.

## Operation
- State machine: IDLE, REQ, WAIT, PRESENT, DONE. Index register `idx`, 3 bits.
- IDLE:
  - `frame_start` or `pending` → REQ, `idx`=0, `pending` cleared.
- REQ:
  - `mem_req`=1, `mem_addr`=BASE_ADDR+idx, mod 2^16, wrapping.
  - On grant → WAIT, latency counter loaded with `RD_LAT`-1.
  - Otherwise stay in REQ; the address must not change.
- WAIT:
  - Decrement the latency counter.
  - At the edge where it reads 0: capture `mem_rdata` into the data register → PRESENT.
- PRESENT, exactly 1 cycle:
  - `vga_counter`=idx; `data_from_mem_vga`=captured word.
  - If idx==NUM_WORDS-1 → DONE; else idx+1 → REQ.
- DONE, 1 cycle:
  - `frame_done`=1.
  - → REQ with idx=0 if `pending`, else → IDLE.
- `frame_start` while not in IDLE:
  - Sets `pending`; at most one pending frame is kept.
  - Further pulses are dropped.
  - `frame_start` in the DONE cycle sets `pending`, so the next fetch starts immediately.
- One outstanding request at a time; the requester never issues a new request before the capture.
- Outputs other than `mem_req`/`mem_addr`/`vga_counter` are registered; `vga_counter` is decoded from the registered state and `idx`, with no dependence on inputs.
- Reset, synchronous, when `btn_rst_n`=0 at a rising edge:
  - State IDLE, idx=0, `pending`=0.
  - `mem_req`=0, `mem_addr`=16'h0000.
  - `vga_counter`=3'b111, `data_from_mem_vga`=16'h0000.
  - `busy`=0, `frame_done`=0.
  - Reset mid-fetch abandons the transfer; `mem_rdata` returned afterwards is ignored.

## Timing
- Per word: 1 REQ cycle, plus grant stall cycles, plus `RD_LAT` WAIT cycles, plus 1 PRESENT cycle.
- With `RD_LAT`=1 and an immediate grant, counting the `frame_start` cycle as cycle 0:
  - REQ in cycle 1, WAIT in cycle 2, PRESENT idx0 in cycle 3.
  - PRESENT idx*k* in cycle 3+3k; idx5 in cycle 18.
  - `frame_done` in cycle 19; `busy` high in cycles 1–19.
- `vga_counter` ≠ 3'b111 for exactly one cycle per word. This gives the bit generator a full negedge window with stable data.
- A full fetch with an immediate grant takes ≤ NUM_WORDS·(RD_LAT+2)+1 cycles, well inside vblank.

## Test plan
- Basic fetch:
  - Stimulus: memory at 0x0000..0x0005 holds 0x0010, 0x0020, 0x0100, 0x0120, 0x0200, 0x0130; `RD_LAT`=1, `mem_gnt` tied high; one `frame_start`.
  - Response: `vga_counter` 0..5 with those words in cycles 3, 6, …, 18; `frame_done` in cycle 19; `vga_counter`=3'b111 in all other cycles.
- Grant stall:
  - Stimulus: `mem_gnt` low for 4 cycles on word 2.
  - Response: `mem_addr`=0x0002 is held for 5 REQ cycles; word 2 is still presented correctly; `frame_done` is delayed by 4 cycles.
- Latency:
  - Stimulus: `RD_LAT`=3; memory returns 0xDEAD only in the cycle 3 after the grant, garbage otherwise.
  - Response: 0xDEAD is presented.
- Overlapping frames:
  - Stimulus: `frame_start` pulses in cycles 0, 5 and 9.
  - Response: exactly two complete fetches back-to-back; the second REQ follows the DONE cycle directly.
- Reset mid-fetch:
  - Stimulus: `btn_rst_n` low in cycle 7.
  - Response: next cycle `mem_req`=0, `vga_counter`=3'b111, `data_from_mem_vga`=0; no `frame_done`; the next `frame_start` fetches from idx 0.
- Address wrap:
  - Stimulus: `BASE_ADDR`=16'hFFFE.
  - Response: addresses FFFE, FFFF, 0000, 0001, 0002, 0003.
